// File: rtl/avalon_block_master_pkg.sv
// avalon_master_pkg: shared state encoding and constants for the Avalon block master.
package avalon_master_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_e;
  localparam int RD_LAT_MAX = 4;
  localparam logic [15:0] BE_ALL = '1;
endpackage

// File: rtl/avalon_block_master_if.sv
// avalon_block_master_if: command, write/read streams and Avalon-MM slave port bundle.
interface avalon_block_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
);
  localparam int BE_W = DATA_W / 8;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_read;
  logic [BE_W-1:0]   avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_clken;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, wr_data, wr_valid, avm_readdata,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, busy, avm_address, avm_chipselect,
           avm_write, avm_read, avm_byteenable, avm_writedata, avm_clken
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, wr_data, wr_valid, avm_readdata,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, busy, avm_address, avm_chipselect,
           avm_write, avm_read, avm_byteenable, avm_writedata, avm_clken
  );
endinterface

// File: rtl/avalon_block_master_rdlat_pipe.sv
// avalon_rdlat_pipe: read-latency valid shift register; tail marks the returning read.
module avalon_rdlat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush_i,
  input  logic push_i,
  output logic tail_o,
  output logic empty_o
);
  logic [DEPTH-1:0] v_q, v_d;
  assign v_d     = flush_i ? '0 : DEPTH'({v_q, push_i});
  assign tail_o  = v_q[DEPTH-1];
  assign empty_o = ~|v_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) v_q <= '0;
    else v_q <= v_d;
endmodule

// File: rtl/avalon_block_master.sv
// avalon_block_master: moves short word bursts between streams and a fixed-latency Avalon-MM memory.
module avalon_block_master
  import avalon_master_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset_n,
  avalon_block_master_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = RD_LAT < 1 ? 1 : RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : RD_LAT;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              wr_beat, issue, pipe_tail, pipe_empty, in_xfer;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        addr_d  = bus.cmd_addr;
        cnt_d   = bus.cmd_len;
        be_d    = bus.cmd_be;
        state_d = bus.cmd_len == '0 ? FIN : bus.cmd_write ? WR : RD;
      end
      WR: if (bus.wr_valid) begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == LEN_W'(1) ? FIN : WR;
      end
      RD: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == LEN_W'(1) ? DRAIN : RD;
      end
      DRAIN: state_d = pipe_empty ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  assign wr_beat = state_q == WR && bus.wr_valid;
  assign issue   = state_q == RD;
  assign in_xfer = state_q == WR || issue;
  avalon_rdlat_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (state_q == IDLE),
    .push_i  (issue),
    .tail_o  (pipe_tail),
    .empty_o (pipe_empty)
  );
  assign bus.cmd_ready      = state_q == IDLE;
  assign bus.busy           = state_q != IDLE;
  assign bus.done           = state_q == FIN;
  assign bus.wr_ready       = state_q == WR;
  assign bus.avm_write      = wr_beat;
  assign bus.avm_read       = issue;
  assign bus.avm_chipselect = wr_beat | issue;
  assign bus.avm_address    = in_xfer ? addr_q : '0;
  assign bus.avm_byteenable = state_q == WR ? be_q : issue ? BE_ALL[BE_W-1:0] : '0;
  assign bus.avm_writedata  = state_q == WR ? bus.wr_data : '0;
  assign bus.avm_clken      = 1'b1;
  // Return data is passed straight through only while the pipe tail says it is ours.
  assign bus.rd_valid       = pipe_tail;
  assign bus.rd_data        = pipe_tail ? bus.avm_readdata : '0;
endmodule

// File: tb/tb_avalon_block_master.sv
// tb_avalon_block_master: scoreboard bench with an on-chip memory model behind the master.
module tb_avalon_block_master;
  localparam int AW = 2, DW = 32, LW = 3, BW = 4;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } wr_t;
  logic clk = 0, reset_n = 0, prev_rd = 0;
  logic [DW-1:0] mem [4];
  logic [DW-1:0] ref_mem [4];
  wr_t wq[$];
  wr_t mon_w;
  logic [AW-1:0] raq[$];
  logic [DW-1:0] rdq[$];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  avalon_block_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  avalon_block_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] n, logic [BW-1:0] be);
    logic [DW-1:0] r;
    for (int b = 0; b < BW; b++) r[8*b+:8] = be[b] ? n[8*b+:8] : o[8*b+:8];
    return r;
  endfunction
  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write)
      mem[bus.avm_address] <= merge(mem[bus.avm_address], bus.avm_writedata, bus.avm_byteenable);
    bus.avm_readdata <= mem[bus.avm_address];
  end
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_write) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          mon_w = wq.pop_front();
          chk("wr_addr", bus.avm_address, mon_w.a);
          chk("wr_data", bus.avm_writedata, mon_w.d);
          chk("wr_be", bus.avm_byteenable, mon_w.be);
        end
      end
      if (bus.avm_read) begin
        if (raq.size() == 0) chk("rd_issue_unexpected", 1, 0);
        else chk("rd_addr", bus.avm_address, raq.pop_front());
        chk("rd_be", bus.avm_byteenable, 4'hF);
      end
      if (bus.avm_write || bus.avm_read) chk("rw_excl", bus.avm_write & bus.avm_read, 0);
      if (bus.rd_valid) begin
        chk("rd_lat", prev_rd, 1);
        if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", bus.rd_data, rdq.pop_front());
      end
      prev_rd = bus.avm_read;
    end else prev_rd = 0;
  end
  task automatic send_cmd(logic w, logic [AW-1:0] a, logic [LW-1:0] n, logic [BW-1:0] be);
    bus.cmd_valid = 1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = n; bus.cmd_be = be;
    @(negedge clk) chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk) #1;
    bus.cmd_valid = 0;
  endtask
  task automatic wr_burst(logic [AW-1:0] a, int n, logic [BW-1:0] be, logic [DW-1:0] base, logic [7:0] pat);
    int i = 0, k = 0;
    logic acc;
    for (int j = 0; j < n; j++) begin
      wq.push_back('{AW'(a + j), base + DW'(j), be});
      ref_mem[AW'(a + j)] = merge(ref_mem[AW'(a + j)], base + DW'(j), be);
    end
    send_cmd(1, a, LW'(n), be);
    while (i < n && k < 32) begin
      bus.wr_valid = pat[k%8];
      bus.wr_data  = base + DW'(i);
      @(negedge clk);
      acc = bus.wr_valid && bus.wr_ready;
      if (!bus.wr_valid) begin
        chk("bubble_addr", bus.avm_address, AW'(a + i));
        chk("bubble_cs", bus.avm_chipselect, 0);
      end
      @(posedge clk) #1;
      if (acc) i++;
      k++;
    end
    bus.wr_valid = 0;
    chk("wr_beats", i, n);
    @(negedge clk) chk("wr_done", bus.done, 1);
    @(posedge clk) #1;
  endtask
  task automatic rd_burst(logic [AW-1:0] a, int n);
    int c = 0;
    for (int j = 0; j < n; j++) begin
      raq.push_back(AW'(a + j));
      rdq.push_back(ref_mem[AW'(a + j)]);
    end
    send_cmd(0, a, LW'(n), '0);
    @(negedge clk);
    while (!bus.done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rd_done", bus.done, 1);
    chk("rd_pending", rdq.size(), 0);
    chk("ra_pending", raq.size(), 0);
    @(posedge clk) #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    for (int j = 0; j < 4; j++) begin
      mem[j] = '0;
      ref_mem[j] = '0;
    end
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_be = '0;
    bus.wr_data = '0; bus.wr_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clken", bus.avm_clken, 1);
    chk("rst_cs", bus.avm_chipselect, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk) #1;
    reset_n = 1;
    wr_burst(1, 3, 4'hF, 32'hA0, 8'hFF);
    rd_burst(3, 3);
    wr_burst(2, 2, 4'hF, 32'hB0, 8'b101);
    rd_burst(2, 2);
    wr_burst(0, 1, 4'hF, 32'h12345678, 8'hFF);
    wr_burst(0, 1, 4'b0011, 32'hFFFFFFFF, 8'hFF);
    rd_burst(0, 1);
    send_cmd(1, 2, 0, 4'hF);
    @(negedge clk);
    chk("len0_busy", bus.busy, 1);
    chk("len0_done", bus.done, 1);
    chk("len0_cs", bus.avm_chipselect, 0);
    @(negedge clk);
    chk("len0_busy_end", bus.busy, 0);
    chk("len0_done_end", bus.done, 0);
    @(posedge clk) #1;
    raq.push_back(1);
    send_cmd(0, 1, 3, '0);
    @(posedge clk) #1;
    reset_n = 0;
    #1;
    chk("mid_rst_cs", bus.avm_chipselect, 0);
    chk("mid_rst_read", bus.avm_read, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_ra_seen", raq.size(), 0);
    raq.delete();
    rdq.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk) chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    for (int j = 0; j < 4; j++) begin
      chk("post_rst_rd_valid", bus.rd_valid, 0);
      chk("post_rst_done", bus.done, 0);
      @(negedge clk);
    end
    @(posedge clk) #1;
    rd_burst(1, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
